// File: rtl/shift_arbiter.sv
// Round-robin arbiter granting one of four requesters a fixed-length burst on a
// shared shift-register datapath, with abort on request drop and a saturating burst counter.
module shift_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 8
) (
  input  logic               clk_ff,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               shift_enable,
  output logic               shift_din,
  output logic               busy,
  output logic [1:0]         cur_id,
  output logic [15:0]        burst_count
);

  localparam int ID_W   = 2;
  localparam int BEAT_W = 7;
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [NUM_REQ-1:0] NONE      = NUM_REQ'(0);
  localparam logic [15:0]        COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [BEAT_W-1:0]   beat_r;
  logic [NUM_REQ-1:0]  grant_r;
  logic [NUM_REQ-1:0]  done_r;
  logic [15:0]         burst_count_r;
  logic [ID_W-1:0]     cur_id_r;
  logic [ID_W-1:0]     last_id_r;
  logic [ID_W-1:0]     cand_s;
  logic [ID_W-1:0]     winner_s;
  logic                found_s;
  logic                shift_enable_s;
  logic                shift_din_s;

  // Round-robin search starting just after the last winner.
  always_comb begin
    found_s  = 1'b0;
    winner_s = last_id_r;
    cand_s   = last_id_r;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = ID_W'((int'(last_id_r) + i) % NUM_REQ);
      if (!found_s && req[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Datapath steering: the granted requester's live request gates the shift.
  always_comb begin
    shift_enable_s = 1'b0;
    shift_din_s    = 1'b0;
    if (!reset && (state_r == ST_SHIFT)) begin
      shift_enable_s = req[cur_id_r];
      shift_din_s    = req[cur_id_r] & din[cur_id_r];
    end else begin
      shift_enable_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!req[cur_id_r]) begin
          state_s = ST_IDLE;
        end else if (beat_r == LAST_BEAT) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_ff) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant, done, beat counter, burst counter and requester ids.
  always_ff @(posedge clk_ff) begin
    if (reset) begin
      grant_r       <= NONE;
      done_r        <= NONE;
      beat_r        <= {BEAT_W{1'b0}};
      burst_count_r <= 16'd0;
      cur_id_r      <= 2'd0;
      last_id_r     <= ID_W'(NUM_REQ - 1);
    end else begin
      done_r <= NONE;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            cur_id_r  <= winner_s;
            last_id_r <= winner_s;
            grant_r   <= ONE_HOT0 << winner_s;
            beat_r    <= {BEAT_W{1'b0}};
          end
        end
        ST_SHIFT: begin
          if (!req[cur_id_r]) begin
            grant_r <= NONE;
          end else begin
            beat_r <= beat_r + 7'd1;
            if (beat_r == LAST_BEAT) begin
              done_r <= ONE_HOT0 << cur_id_r;
            end
          end
        end
        ST_DONE: begin
          grant_r <= NONE;
          if (burst_count_r != COUNT_MAX) begin
            burst_count_r <= burst_count_r + 16'd1;
          end
        end
        default: begin
          grant_r <= NONE;
        end
      endcase
    end
  end

  assign grant        = grant_r;
  assign done         = done_r;
  assign shift_enable = shift_enable_s;
  assign shift_din    = shift_din_s;
  assign busy         = ~reset & (state_r != ST_IDLE);
  assign cur_id       = cur_id_r;
  assign burst_count  = burst_count_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized bench for shift_arbiter: two instances (BURST_LEN 8 and 1) share the
// stimulus and are compared every cycle against a burst-level reference model.
module tb_shift_arbiter;

  logic        clk_ff;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  din;

  logic [3:0]  grant8, done8, grant1, done1;
  logic        se8, sd8, busy8, se1, sd1, busy1;
  logic [1:0]  cid8, cid1;
  logic [15:0] bc8, bc1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit active;
    bit fin;
    int owner;
    int beats;
    int cur;
    int last;
    int count;
  } mdl_t;

  mdl_t m8;
  mdl_t m1;

  shift_arbiter #(.NUM_REQ(4), .BURST_LEN(8)) dut8 (
    .clk_ff(clk_ff), .reset(reset), .req(req), .din(din),
    .grant(grant8), .done(done8), .shift_enable(se8), .shift_din(sd8),
    .busy(busy8), .cur_id(cid8), .burst_count(bc8)
  );

  shift_arbiter #(.NUM_REQ(4), .BURST_LEN(1)) dut1 (
    .clk_ff(clk_ff), .reset(reset), .req(req), .din(din),
    .grant(grant1), .done(done1), .shift_enable(se1), .shift_din(sd1),
    .busy(busy1), .cur_id(cid1), .burst_count(bc1)
  );

  initial begin
    clk_ff = 1'b0;
    forever #5 clk_ff = ~clk_ff;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.active = 1'b0;
    m.fin    = 1'b0;
    m.owner  = 0;
    m.beats  = 0;
    m.cur    = 0;
    m.last   = 3;
    m.count  = 0;
    return m;
  endfunction

  // One clock edge of the burst-level behaviour.
  function automatic mdl_t mdl_step(input mdl_t m, input bit rst, input logic [3:0] r, input int bl);
    mdl_t n;
    bit   got;
    n = m;
    if (rst) begin
      n = mdl_reset();
    end else if (m.fin) begin
      n.fin = 1'b0;
      if (m.count < 65535) n.count = m.count + 1;
    end else if (m.active) begin
      if (!r[m.owner]) begin
        n.active = 1'b0;
      end else begin
        n.beats = m.beats + 1;
        if (n.beats == bl) begin
          n.active = 1'b0;
          n.fin    = 1'b1;
        end
      end
    end else if (r != 4'd0) begin
      got = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (!got && r[(m.last + k) % 4]) begin
          got     = 1'b1;
          n.owner = (m.last + k) % 4;
        end
      end
      n.active = 1'b1;
      n.beats  = 0;
      n.cur    = n.owner;
      n.last   = n.owner;
    end
    return n;
  endfunction

  task automatic check_outputs(input string who, input mdl_t m,
                               input logic [3:0] g, input logic [3:0] d,
                               input logic se, input logic sd, input logic b,
                               input logic [1:0] cid, input logic [15:0] bc);
    logic [3:0] oh;
    bit on, se_exp;
    oh     = 4'b0001 << m.owner;
    on     = m.active || m.fin;
    se_exp = !reset && m.active && req[m.owner];
    check({who, ".grant"}, 32'(g), on ? 32'(oh) : 32'd0);
    check({who, ".done"}, 32'(d), m.fin ? 32'(oh) : 32'd0);
    check({who, ".shift_enable"}, 32'(se), 32'(se_exp));
    check({who, ".shift_din"}, 32'(sd), 32'(se_exp && din[m.owner]));
    check({who, ".busy"}, 32'(b), 32'(!reset && on));
    check({who, ".cur_id"}, 32'(cid), 32'(m.cur));
    check({who, ".burst_count"}, 32'(bc), 32'(m.count));
  endtask

  // Drive one cycle at the falling edge, compare, then advance the models.
  task automatic cycle(input bit rst, input logic [3:0] r, input logic [3:0] d);
    @(negedge clk_ff);
    reset = rst;
    req   = r;
    din   = d;
    #1;
    check_outputs("bl8", m8, grant8, done8, se8, sd8, busy8, cid8, bc8);
    check_outputs("bl1", m1, grant1, done1, se1, sd1, busy1, cid1, bc1);
    @(posedge clk_ff);
    m8 = mdl_step(m8, rst, r, 8);
    m1 = mdl_step(m1, rst, r, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g_q[$];
    int         i_q[$];
    logic [3:0] prev_g;
    logic [3:0] r;
    int         guard;

    reset = 1'b1;
    req   = 4'd0;
    din   = 4'd0;
    repeat (2) @(posedge clk_ff);
    m8 = mdl_reset();
    m1 = mdl_reset();
    cycle(1'b1, 4'd0, 4'd0);

    // Single burst from requester 2 with toggling data.
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'b0100, (i % 2 == 1) ? 4'b0100 : 4'b0000);
    #1;
    check("single.count", 32'(bc8), 32'd1);

    // Fairness: all request, four bursts after reset.
    cycle(1'b1, 4'b1111, 4'd0);
    prev_g = 4'd0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 4'b1111, 4'($urandom_range(0, 15)));
      #1;
      if (prev_g == 4'd0 && grant8 != 4'd0) begin
        g_q.push_back(grant8);
        i_q.push_back(i);
      end
      prev_g = grant8;
    end
    check("fair.bursts", 32'(g_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < g_q.size(); k++) check("fair.order", 32'(g_q[k]), 32'(1 << k));
    for (int k = 1; k < 4 && k < i_q.size(); k++) check("fair.gap", 32'(i_q[k] - i_q[k-1]), 32'd10);
    check("fair.count", 32'(bc8), 32'd4);

    // Abort: requester 1 drops on its fourth beat; requester 2 is waiting.
    guard = 0;
    while (!(m8.active && m8.beats == 3) && guard < 20) begin
      cycle(1'b0, 4'b0010, 4'b0010);
      guard++;
    end
    check("abort.reach", 32'(guard < 20), 32'd1);
    cycle(1'b0, 4'b0100, 4'b0010);
    #1;
    check("abort.busy", 32'(busy8), 32'd0);
    check("abort.count", 32'(bc8), 32'd4);
    cycle(1'b0, 4'b0100, 4'b0000);
    #1;
    check("abort.next", 32'(cid8), 32'd2);

    // Reset during beat 5 of requester 3's burst.
    cycle(1'b0, 4'b0000, 4'b0000);
    guard = 0;
    while (!(m8.active && m8.beats == 5) && guard < 20) begin
      cycle(1'b0, 4'b1000, 4'b1000);
      guard++;
    end
    check("rst.reach", 32'(guard < 20), 32'd1);
    cycle(1'b1, 4'b1000, 4'b1000);
    #1;
    check("rst.grant", 32'(grant8), 32'd0);
    check("rst.count", 32'(bc8), 32'd0);
    cycle(1'b0, 4'b1111, 4'b0000);
    #1;
    check("rst.winner", 32'(cid8), 32'd0);
    check("rst.grant0", 32'(grant8), 32'd1);

    // Saturation: preload the counter near its ceiling while idle.
    guard = 0;
    while ((m8.active || m8.fin) && guard < 20) begin
      cycle(1'b0, 4'b0000, 4'b0000);
      guard++;
    end
    check("sat.idle", 32'(guard < 20), 32'd1);
    force dut8.burst_count_r = 16'hFFFE;
    m8.count = 65534;
    cycle(1'b0, 4'b0000, 4'b0000);
    #1;
    release dut8.burst_count_r;
    for (int i = 0; i < 30; i++) cycle(1'b0, 4'b0001, 4'($urandom_range(0, 15)));
    #1;
    check("sat.count", 32'(bc8), 32'hFFFF);

    // Random traffic: the owner mostly keeps requesting, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'd0;
      if (m8.active && $urandom_range(0, 15) != 0) r[m8.owner] = 1'b1;
      cycle($urandom_range(0, 199) == 0, r, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
